// File: rtl/pointer_box_mover.sv
// Moves a BOX_SIZE x BOX_SIZE box around the VGA plot area: erase, move, redraw, one pixel per cycle.
// Define PTR_WRAP_EN to wrap at the screen edges instead of clamping.
module pointer_box_mover #(
  parameter int X_W             = 8,
  parameter int Y_W             = 7,
  parameter int X_MAX           = 159,
  parameter int Y_MAX           = 119,
  parameter int BOX_SIZE        = 4,
  parameter int COLOUR_W        = 3,
  parameter int TICK_DIV        = 833334,
  parameter int FRAMES_PER_STEP = 15,
  parameter int INIT_X          = 0,
  parameter int INIT_Y          = 0
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                left,
  input  logic                right,
  input  logic                up,
  input  logic                down,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [X_W-1:0]      X,
  output logic [Y_W-1:0]      Y,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                busy
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FR_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int OFF_W = 4;

  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TICK_DIV - 1);
  localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(FRAMES_PER_STEP - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BOX_SIZE - 1);
  localparam logic [16:0]      X_LIM    = 17'(X_MAX - BOX_SIZE + 1);
  localparam logic [16:0]      Y_LIM    = 17'(Y_MAX - BOX_SIZE + 1);

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_ERASE = 2'd1,
    S_MOVE  = 2'd2,
    S_DRAW  = 2'd3
  } state_t;

  state_t              r_state;
  logic [X_W-1:0]      r_pos_x;
  logic [Y_W-1:0]      r_pos_y;
  logic [OFF_W-1:0]    r_ox;
  logic [OFF_W-1:0]    r_oy;
  logic [DIV_W-1:0]    r_div;
  logic [FR_W-1:0]     r_frame;
  logic                r_pending;
  logic [COLOUR_W-1:0] r_colour;
  logic [X_W-1:0]      r_x_out;
  logic [Y_W-1:0]      r_y_out;
  logic [COLOUR_W-1:0] r_col_out;
  logic                r_plot;
  logic                r_busy;

  logic                w_frame_tick;
  logic                w_step;
  logic                w_ox_last;
  logic                w_box_last;
  logic                w_box_first;
  logic [X_W-1:0]      w_pix_x;
  logic [Y_W-1:0]      w_pix_y;
  logic [X_W-1:0]      w_next_x;
  logic [Y_W-1:0]      w_next_y;

  // One-pixel step along one axis, computed one bit wider than any coordinate;
  // opposing requests cancel, and an out-of-range result clamps or wraps.
  function automatic logic [16:0] axis_step(input logic [16:0] cur,
                                            input logic        dec,
                                            input logic        inc,
                                            input logic [16:0] lim);
    logic [16:0] nxt;
    nxt = cur;
    if (dec && !inc) begin
      if (cur == 17'd0) begin
`ifdef PTR_WRAP_EN
        nxt = lim;
`else
        nxt = cur;
`endif
      end else begin
        nxt = cur - 17'd1;
      end
    end else if (inc && !dec) begin
      if ((cur + 17'd1) > lim) begin
`ifdef PTR_WRAP_EN
        nxt = 17'd0;
`else
        nxt = cur;
`endif
      end else begin
        nxt = cur + 17'd1;
      end
    end
    return nxt;
  endfunction

  assign w_frame_tick = (r_div == '0);
  assign w_step       = w_frame_tick && (r_frame == FR_LAST);

  assign w_ox_last    = (r_ox == OFF_LAST);
  assign w_box_last   = w_ox_last && (r_oy == OFF_LAST);
  assign w_box_first  = (r_ox == '0) && (r_oy == '0);
  assign w_pix_x      = r_pos_x + X_W'(r_ox);
  assign w_pix_y      = r_pos_y + Y_W'(r_oy);

  always_comb begin
    w_next_x = X_W'(axis_step(17'(r_pos_x), left, right, X_LIM));
    w_next_y = Y_W'(axis_step(17'(r_pos_y), up, down, Y_LIM));
  end

  // Frame-rate divider and step generator, free-running in every state
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      r_div   <= DIV_LOAD;
      r_frame <= '0;
    end else if (w_frame_tick) begin
      r_div <= DIV_LOAD;
      if (w_step) r_frame <= '0;
      else        r_frame <= r_frame + FR_W'(1);
    end else begin
      r_div <= r_div - DIV_W'(1);
    end
  end

  // Box FSM; outputs are registered from the state being executed this cycle
  always_ff @(posedge clock or posedge reset_n) begin
    if (reset_n) begin
      r_state   <= S_DRAW;
      r_pos_x   <= X_W'(INIT_X);
      r_pos_y   <= Y_W'(INIT_Y);
      r_ox      <= '0;
      r_oy      <= '0;
      r_pending <= 1'b0;
      r_colour  <= '0;
      r_x_out   <= X_W'(INIT_X);
      r_y_out   <= Y_W'(INIT_Y);
      r_col_out <= '0;
      r_plot    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      if (w_step && (r_state != S_WAIT)) r_pending <= 1'b1;
      case (r_state)
        S_WAIT: begin
          r_x_out   <= r_pos_x;
          r_y_out   <= r_pos_y;
          r_col_out <= '0;
          r_plot    <= 1'b0;
          r_busy    <= 1'b0;
          if (w_step || r_pending) begin
            r_pending <= 1'b0;
            r_state   <= S_ERASE;
          end
        end
        S_ERASE: begin
          r_x_out   <= w_pix_x;
          r_y_out   <= w_pix_y;
          r_col_out <= '0;
          r_plot    <= 1'b1;
          r_busy    <= 1'b1;
          if (w_ox_last) begin
            r_ox <= '0;
            r_oy <= w_box_last ? '0 : r_oy + OFF_W'(1);
          end else begin
            r_ox <= r_ox + OFF_W'(1);
          end
          if (w_box_last) r_state <= S_MOVE;
        end
        S_MOVE: begin
          r_x_out   <= r_pos_x;
          r_y_out   <= r_pos_y;
          r_col_out <= '0;
          r_plot    <= 1'b0;
          r_busy    <= 1'b1;
          r_pos_x   <= w_next_x;
          r_pos_y   <= w_next_y;
          r_state   <= S_DRAW;
        end
        default: begin
          r_x_out <= w_pix_x;
          r_y_out <= w_pix_y;
          r_plot  <= 1'b1;
          r_busy  <= 1'b1;
          // Colour is captured on the first pixel so it stays fixed for the whole box
          if (w_box_first) begin
            r_colour  <= colour_in;
            r_col_out <= colour_in;
          end else begin
            r_col_out <= r_colour;
          end
          if (w_ox_last) begin
            r_ox <= '0;
            r_oy <= w_box_last ? '0 : r_oy + OFF_W'(1);
          end else begin
            r_ox <= r_ox + OFF_W'(1);
          end
          if (w_box_last) r_state <= S_WAIT;
        end
      endcase
    end
  end

  assign X          = r_x_out;
  assign Y          = r_y_out;
  assign colour_out = r_col_out;
  assign plot       = r_plot;
  assign busy       = r_busy;

endmodule

// File: tb/tb_pointer_box_mover.sv
// Directed bench for pointer_box_mover: 2x2 box at (10,10), plus a step-every-cycle instance.
module tb_pointer_box_mover;

  logic       clock = 1'b0;
  logic       rst_m, rst_f;
  logic       left, right, up, down;
  logic [2:0] colour_in;

  logic [7:0] X, fX;
  logic [6:0] Y, fY;
  logic [2:0] colour_out, fcol;
  logic       plot, busy, fplot, fbusy;

  int n_vec  = 0;
  int n_miss = 0;
  int px, py;

  always #5 clock = ~clock;

  pointer_box_mover #(
    .X_W(8), .Y_W(7), .X_MAX(159), .Y_MAX(119), .BOX_SIZE(2), .COLOUR_W(3),
    .TICK_DIV(4), .FRAMES_PER_STEP(2), .INIT_X(10), .INIT_Y(10)
  ) dut (
    .clock(clock), .reset_n(rst_m), .left(left), .right(right), .up(up), .down(down),
    .colour_in(colour_in), .X(X), .Y(Y), .colour_out(colour_out), .plot(plot), .busy(busy)
  );

  pointer_box_mover #(
    .X_W(8), .Y_W(7), .X_MAX(159), .Y_MAX(119), .BOX_SIZE(2), .COLOUR_W(3),
    .TICK_DIV(1), .FRAMES_PER_STEP(1), .INIT_X(10), .INIT_Y(10)
  ) dut_fast (
    .clock(clock), .reset_n(rst_f), .left(1'b0), .right(1'b0), .up(1'b0), .down(1'b0),
    .colour_in(3'b010), .X(fX), .Y(fY), .colour_out(fcol), .plot(fplot), .busy(fbusy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int model_axis(input int cur, input bit dec, input bit inc, input int lim);
    if (dec && !inc) begin
      if (cur == 0) begin
`ifdef PTR_WRAP_EN
        return lim;
`else
        return 0;
`endif
      end
      return cur - 1;
    end
    if (inc && !dec) begin
      if (cur == lim) begin
`ifdef PTR_WRAP_EN
        return 0;
`else
        return lim;
`endif
      end
      return cur + 1;
    end
    return cur;
  endfunction

  // Waits for a 2x2 burst, checks its four pixels in scan order and the cycle after it.
  task automatic expect_box(input string tag, input int bx, input int by, input logic [2:0] col,
                            input logic busy_after, input bit flip);
    int waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (plot !== 1'b1 && waited < 64);
    if (plot !== 1'b1) begin
      check_val({tag, "_start"}, 32'(plot), 32'd1);
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clock);
      check_val({tag, "_plot"}, 32'(plot), 32'd1);
      check_val({tag, "_x"}, 32'(X), 32'(bx + (i % 2)));
      check_val({tag, "_y"}, 32'(Y), 32'(by + (i / 2)));
      check_val({tag, "_col"}, 32'(colour_out), 32'(col));
      if (flip && i == 0) colour_in = ~colour_in;
    end
    @(negedge clock);
    check_val({tag, "_end_plot"}, 32'(plot), 32'd0);
    check_val({tag, "_end_busy"}, 32'(busy), 32'(busy_after));
    if (!busy_after) begin
      check_val({tag, "_hold_x"}, 32'(X), 32'(bx));
      check_val({tag, "_hold_y"}, 32'(Y), 32'(by));
    end
  endtask

  task automatic do_step(input string tag, input bit l, input bit r, input bit u, input bit d,
                         input bit flip);
    int nx, ny;
    logic [2:0] c;
    left = l; right = r; up = u; down = d;
    expect_box({tag, "_erase"}, px, py, 3'b000, 1'b1, 1'b0);
    nx = model_axis(px, l, r, 158);
    ny = model_axis(py, u, d, 118);
    c  = colour_in;
    expect_box({tag, "_draw"}, nx, ny, c, 1'b0, flip);
    px = nx;
    py = ny;
  endtask

  initial begin
    int pc, ic, waited;
    rst_m = 1'b1; rst_f = 1'b1;
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    colour_in = 3'b100;
    repeat (3) @(negedge clock);
    check_val("rst_x", 32'(X), 32'd10);
    check_val("rst_y", 32'(Y), 32'd10);
    check_val("rst_col", 32'(colour_out), 32'd0);
    check_val("rst_plot", 32'(plot), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_fast_plot", 32'(fplot), 32'd0);

    // Step every cycle: pending steps collapse to one, one WAIT cycle between steps
    rst_f = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_val("fast_init_plot", 32'(fplot), 32'd1);
      if (i == 0) check_val("fast_init_x", 32'(fX), 32'd10);
    end
    for (int k = 0; k < 3; k++) begin
      pc = 0; ic = 0;
      for (int j = 0; j < 10; j++) begin
        @(negedge clock);
        if (fplot) pc++;
        if (!fbusy) ic++;
        if (j == 0) check_val("fast_wait_slot", 32'(fbusy), 32'd0);
      end
      check_val("fast_plots_per_step", 32'(pc), 32'd8);
      check_val("fast_wait_cycles", 32'(ic), 32'd1);
    end

    rst_m = 1'b0;
    px = 10; py = 10;
    expect_box("init_draw", 10, 10, 3'b100, 1'b0, 1'b0);

    do_step("right", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++)
      do_step("left_up", 1'b1, 1'b0, 1'b1, 1'b0, (i == 4));
    for (int i = 0; i < 10; i++)
      do_step("right_down", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 109; i++)
      do_step("down", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_step("lr_down", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    do_step("lr_only", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Abort a draw after two pixels with an asynchronous reset
    left = 1'b0; right = 1'b0; up = 1'b0; down = 1'b0;
    expect_box("abort_erase", px, py, 3'b000, 1'b1, 1'b0);
    waited = 0;
    do begin
      @(negedge clock);
      waited++;
    end while (plot !== 1'b1 && waited < 64);
    check_val("abort_first_x", 32'(X), 32'(px));
    @(negedge clock);
    check_val("abort_second_plot", 32'(plot), 32'd1);
    rst_m = 1'b1;
    #1;
    check_val("abort_plot", 32'(plot), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_x", 32'(X), 32'd10);
    check_val("abort_y", 32'(Y), 32'd10);
    repeat (2) @(negedge clock);
    rst_m = 1'b0;
    px = 10; py = 10;
    expect_box("redraw", 10, 10, colour_in, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
